dc_blocker_sched: RTL and testbench

Time-multiplexed DC-blocking filter engine for the Pocket audio path. It shares one 40-bit DC-blocker datapath between up to eight 16-bit sample streams and keeps per-channel filter state in a register bank. A round-robin arbiter accepts one sample at a time, runs it through the filter and presents the result with a valid/ready handshake. It sits between the core's audio sources and the audio mixer/I2S serializer.

---
 rtl/dc_blocker_sched.sv | 171 +++++++++++++++++
 tb/tb_dc_blocker_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_blocker_sched.sv
// Time-multiplexed DC blocker: one 40-bit datapath shared round-robin between CHANNELS streams.
// Define DC_BLOCKER_SCHED_SAT_FLAGS_EN to build the sticky per-channel saturation flags.

module dc_blocker_sched_lane (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        we,
    input  logic [39:0] x1_d,
    input  logic [39:0] y_d,
    output logic [39:0] x1_q,
    output logic [39:0] y_q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1_q <= '0;
            y_q  <= '0;
        end else if (clr) begin
            x1_q <= '0;
            y_q  <= '0;
        end else if (we) begin
            x1_q <= x1_d;
            y_q  <= y_d;
        end
    end
endmodule

module dc_blocker_sched #(
    parameter  int CHANNELS = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_rate,
    input  logic                    clear,
    input  logic [CHANNELS-1:0]     mute,
    input  logic [CHANNELS-1:0]     in_valid,
    input  logic [16*CHANNELS-1:0]  in_data,
    output logic [CHANNELS-1:0]     in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW-1:0]           out_ch,
    output logic [15:0]             out_data,
    output logic [CHANNELS-1:0]     sat_flags,
    input  logic                    sat_clr
);
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              last_grant, cur_ch, grant_ch, cand;
    logic                       grant_ok, accept, calc_fire;
    logic [15:0]                cur_data;
    logic [CHANNELS-1:0][39:0]  x1_bank, y_bank;

    logic [3:0]                 k_sh, k1_sh;
    logic signed [39:0]         x, x0, x1_cur, y_cur, y1, y0, ynew;
    logic                       sat;

    // Walk from last_grant+1 around the ring; the last hit in descending order is the nearest.
    always_comb begin
        grant_ok = 1'b0;
        grant_ch = '0;
        cand     = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand = CW'((int'(last_grant) + i) % CHANNELS);
            if (in_valid[cand]) begin
                grant_ok = 1'b1;
                grant_ch = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        accept    = 1'b0;
        calc_fire = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (grant_ok) begin
                    in_ready[grant_ch] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = CALC;
                end
                CALC: begin
                    calc_fire = 1'b1;
                    state_nxt = OUT;
                end
                OUT:     if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign out_valid = (state == OUT);

    // Filter datapath; intermediates wrap at 40 bits, only the result is clamped.
    always_comb begin
        k_sh   = sample_rate ? 4'd11 : 4'd10;
        k1_sh  = k_sh - 4'd1;
        x      = {cur_data[15], cur_data, 23'b0};
        x1_cur = x1_bank[cur_ch];
        y_cur  = y_bank[cur_ch];
        x0     = x - (x >>> k_sh);
        y1     = y_cur - (y_cur >>> k1_sh);
        y0     = x0 - x1_cur + y1;
        sat    = y0[39] ^ y0[38];
        ynew   = sat ? {y0[39], y0[39], {38{y0[38]}}} : y0;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        dc_blocker_sched_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clear),
            .we      (calc_fire && (cur_ch == CW'(g))),
            .x1_d    (x0),
            .y_d     (ynew),
            .x1_q    (x1_bank[g]),
            .y_q     (y_bank[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= CW'(CHANNELS - 1);
            cur_ch     <= '0;
            cur_data   <= '0;
            out_ch     <= '0;
            out_data   <= '0;
        end else if (clear) begin
            last_grant <= CW'(CHANNELS - 1);
        end else begin
            if (accept) begin
                cur_ch   <= grant_ch;
                cur_data <= in_data[16*int'(grant_ch) +: 16];
            end
            if (calc_fire) begin
                out_ch   <= cur_ch;
                out_data <= mute[cur_ch] ? 16'h0000 : ynew[38:23];
            end
            if (out_valid && out_ready) last_grant <= cur_ch;
        end
    end

`ifdef DC_BLOCKER_SCHED_SAT_FLAGS_EN
    // A saturation in the same cycle as sat_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flags <= '0;
        end else if (clear) begin
            sat_flags <= '0;
        end else begin
            if (sat_clr) sat_flags <= '0;
            if (calc_fire && sat) sat_flags[cur_ch] <= 1'b1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = sat_clr ^ sat;
    assign sat_flags  = '0;
`endif

endmodule

// File: tb/tb_dc_blocker_sched.sv
// Randomized and directed bench for dc_blocker_sched against an arithmetic reference model.
module tb_dc_blocker_sched;
    localparam int CH = 4;
`ifdef DC_BLOCKER_SCHED_SAT_FLAGS_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam longint MAXV = (longint'(1) <<< 38) - 1;
    localparam longint MINV = -(longint'(1) <<< 38);

    logic            clk = 1'b0;
    logic            reset_n, sample_rate, clear, out_ready, sat_clr, out_valid;
    logic [CH-1:0]   mute, in_valid, in_ready, sat_flags;
    logic [16*CH-1:0] in_data;
    logic [1:0]      out_ch;
    logic [15:0]     out_data;

    int checks = 0;
    int errors = 0;
    longint x1m [CH];
    longint ym  [CH];
    int lg_m;

    dc_blocker_sched #(.CHANNELS(CH)) dut (
        .clk(clk), .reset_n(reset_n), .sample_rate(sample_rate), .clear(clear),
        .mute(mute), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .sat_flags(sat_flags), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            x1m[i] = 0;
            ym[i]  = 0;
        end
        lg_m = CH - 1;
    endtask

    // Reference filter step in plain 64-bit arithmetic.
    task automatic model_calc(input int ch, input logic [15:0] d, input logic sr,
                              output logic [15:0] y16, output bit s);
        longint x, x0, y1, y0;
        int k;
        k  = sr ? 11 : 10;
        x  = longint'($signed(d)) <<< 23;
        x0 = wrap40(x - (x >>> k));
        y1 = ym[ch] - (ym[ch] >>> (k - 1));
        y0 = wrap40(x0 - x1m[ch] + y1);
        s  = (y0 > MAXV) || (y0 < MINV);
        if (y0 > MAXV) y0 = MAXV;
        else if (y0 < MINV) y0 = MINV;
        x1m[ch] = x0;
        ym[ch]  = y0;
        y16 = 16'(y0 >>> 23);
    endtask

    function automatic int pick(input logic [CH-1:0] v, input int lg);
        for (int off = 1; off <= CH; off++)
            if (v[(lg + off) % CH]) return (lg + off) % CH;
        return -1;
    endfunction

    task automatic do_sample(input int ch, input logic [15:0] d, output logic [15:0] od,
                             output logic [1:0] och, output int lat, output bit ok);
        int w;
        ok = 1'b0; lat = 0; od = '0; och = '0;
        in_valid = '0;
        in_valid[ch] = 1'b1;
        in_data[16*ch +: 16] = d;
        #1;
        w = 0;
        while (in_ready[ch] !== 1'b1 && w < 20) begin tick(); #1; w++; end
        if (w >= 20) begin in_valid = '0; return; end
        tick();
        in_valid = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        if (out_valid !== 1'b1) return;
        od = out_data; och = out_ch; ok = 1'b1;
        if (out_ready) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_rate = 1'b0; clear = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        mute = '0; in_valid = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b ch=%0d data=%h want 0/0/0000", out_valid, out_ch, out_data);
        end
        checks++;
        if (sat_flags !== '0 || in_ready !== '0) begin
            errors++;
            $display("FAIL reset_flags: sat=%b in_ready=%b want 0/0", sat_flags, in_ready);
        end
    endtask

    task automatic test_step();
        logic [15:0] od, ey; logic [1:0] och; int lat; bit ok, s;
        sample_rate = 1'b0;
        do_sample(0, 16'h4000, od, och, lat, ok);
        model_calc(0, 16'h4000, 1'b0, ey, s);
        checks++;
        if (!ok || lat != 2) begin errors++; $display("FAIL step_latency: got %0d want 2", lat); end
        checks++;
        if (och !== 2'd0 || od !== 16'h3FF0 || ey !== 16'h3FF0) begin
            errors++;
            $display("FAIL step_first: ch=%0d data=%h model=%h want 0/3ff0", och, od, ey);
        end
        for (int n = 1; n < 8192; n++) begin
            do_sample(0, 16'h4000, od, och, lat, ok);
            model_calc(0, 16'h4000, 1'b0, ey, s);
            checks++;
            if (!ok || od !== ey) begin
                errors++;
                $display("FAIL step_seq[%0d]: got %h want %h", n, od, ey);
            end
        end
        lg_m = 0;
        checks++;
        if ($signed(od) > 1 || $signed(od) < -1) begin
            errors++;
            $display("FAIL step_settle: got %h want within 1 of 0000", od);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] ey; bit s; int g, outs, last_cyc;
        logic [1:0] qch [$]; logic [15:0] qd [$];
        int order [5] = '{0, 1, 2, 3, 0};
        clear = 1'b1; tick(); clear = 1'b0;
        model_reset();
        sample_rate = 1'b0; out_ready = 1'b1; mute = '0;
        for (int i = 0; i < CH; i++) in_data[16*i +: 16] = 16'(16'h0100 * (i + 1));
        in_valid = '1;
        g = 0; outs = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && outs < 5; cyc++) begin
            #1;
            if (in_ready !== '0 && g < 5) begin
                checks++;
                if (in_ready !== CH'(1 << order[g]) || (g > 0 && cyc - last_cyc != 3)) begin
                    errors++;
                    $display("FAIL fair_grant[%0d]: in_ready=%b gap=%0d want %b gap 3", g, in_ready, cyc - last_cyc, CH'(1 << order[g]));
                end
                model_calc(order[g], 16'(16'h0100 * (order[g] + 1)), 1'b0, ey, s);
                qch.push_back(2'(order[g])); qd.push_back(ey);
                last_cyc = cyc; g++;
            end
            if (out_valid === 1'b1 && qch.size() > 0) begin
                checks++;
                if (out_ch !== qch[0] || out_data !== qd[0]) begin
                    errors++;
                    $display("FAIL fair_out[%0d]: ch=%0d data=%h want %0d/%h", outs, out_ch, out_data, qch[0], qd[0]);
                end
                void'(qch.pop_front()); void'(qd.pop_front());
                outs++;
            end
            tick();
        end
        in_valid = '0;
        checks++;
        if (outs != 5 || g != 5) begin errors++; $display("FAIL fair_count: grants=%0d outs=%0d want 5/5", g, outs); end
        lg_m = 0;
    endtask

    task automatic test_backpressure();
        logic [15:0] od, ey; logic [1:0] och; int lat; bit ok, s;
        out_ready = 1'b0;
        do_sample(3, 16'h1234, od, och, lat, ok);
        model_calc(3, 16'h1234, sample_rate, ey, s);
        checks++;
        if (!ok || od !== ey || och !== 2'd3) begin
            errors++;
            $display("FAIL bp_data: ch=%0d data=%h want 3/%h", och, od, ey);
        end
        in_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== ey || in_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b ch=%0d data=%h rdy=%b want 1/3/%h/0", i, out_valid, out_ch, out_data, in_ready, ey);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release: v=%b rdy=%b want 0/0001", out_valid, in_ready);
        end
        in_valid = '0;
        lg_m = 3;
        tick();
    endtask

    task automatic test_saturation();
        logic [15:0] od, ey; logic [1:0] och; int lat; bit ok, s;
        sample_rate = 1'b0;
        for (int n = 0; n < 8192; n++) begin
            do_sample(1, 16'h8000, od, och, lat, ok);
            model_calc(1, 16'h8000, 1'b0, ey, s);
            checks++;
            if (!ok || od !== ey) begin errors++; $display("FAIL sat_neg[%0d]: got %h want %h", n, od, ey); end
        end
        do_sample(1, 16'h7FFF, od, och, lat, ok);
        model_calc(1, 16'h7FFF, 1'b0, ey, s);
        lg_m = 1;
        checks++;
        if (!ok || od !== 16'h7FFF || ey !== 16'h7FFF || !s) begin
            errors++;
            $display("FAIL sat_out: got %h model %h want 7fff", od, ey);
        end
        checks++;
        if (sat_flags[1] !== SAT_EN) begin
            errors++;
            $display("FAIL sat_flag: got %b want %b", sat_flags[1], SAT_EN);
        end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        checks++;
        if (sat_flags !== '0) begin errors++; $display("FAIL sat_clr: got %b want 0", sat_flags); end
    endtask

    task automatic test_mute();
        logic [15:0] od, ey; logic [1:0] och; int lat; bit ok, s;
        mute = 4'b0100;
        do_sample(2, 16'h4000, od, och, lat, ok);
        model_calc(2, 16'h4000, sample_rate, ey, s);
        checks++;
        if (!ok || od !== 16'h0000 || och !== 2'd2) begin
            errors++;
            $display("FAIL mute_on: ch=%0d data=%h want 2/0000", och, od);
        end
        mute = '0;
        do_sample(2, 16'h4000, od, och, lat, ok);
        model_calc(2, 16'h4000, sample_rate, ey, s);
        checks++;
        if (!ok || od !== ey) begin errors++; $display("FAIL mute_off: got %h want %h", od, ey); end
        lg_m = 2;
    endtask

    task automatic test_clear();
        logic [15:0] od; logic [1:0] och; int lat, w; bit ok, seen;
        sample_rate = 1'b0; out_ready = 1'b1;
        in_valid = 4'b0001; in_data[15:0] = 16'h5555;
        #1;
        w = 0;
        while (in_ready[0] !== 1'b1 && w < 20) begin tick(); #1; w++; end
        tick();
        in_valid = '0;
        clear = 1'b1; tick(); clear = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin if (out_valid !== 1'b0) seen = 1'b1; tick(); end
        checks++;
        if (w >= 20 || seen) begin errors++; $display("FAIL clear_drop: out_valid seen=%b want 0", seen); end
        do_sample(0, 16'h4000, od, och, lat, ok);
        x1m[0] = 0; ym[0] = 0;
        begin logic [15:0] ey; bit s; model_calc(0, 16'h4000, 1'b0, ey, s); end
        checks++;
        if (!ok || od !== 16'h3FF0) begin errors++; $display("FAIL clear_state: got %h want 3ff0", od); end
        out_ready = 1'b0;
        do_sample(1, 16'h1111, od, och, lat, ok);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || out_valid !== 1'b0 || out_data !== 16'h0 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b data=%h ch=%0d want 0/0000/0", out_valid, out_data, out_ch);
        end
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        int phase, pch, g;
        logic [15:0] pdata, exp_d, y16;
        logic [CH-1:0] exp_rdy, sat_m, nsat;
        bit s;
        phase = 0; pch = 0; pdata = '0; exp_d = '0; sat_m = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid    = CH'($urandom_range(0, 15));
            in_data     = {$urandom(), $urandom()};
            sample_rate = 1'($urandom_range(0, 1));
            mute        = CH'($urandom_range(0, 15));
            out_ready   = ($urandom_range(0, 3) != 0);
            sat_clr     = ($urandom_range(0, 15) == 0);
            #1;
            exp_rdy = '0;
            g = -1;
            if (phase == 0) begin
                g = pick(in_valid, lg_m);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, exp_rdy); end
            checks++;
            if (out_valid !== (phase == 2) || (phase == 2 && (out_ch !== 2'(pch) || out_data !== exp_d))) begin
                errors++;
                $display("FAIL rnd_out[%0d]: v=%b ch=%0d data=%h want %b/%0d/%h", cyc, out_valid, out_ch, out_data, phase == 2, pch, exp_d);
            end
            checks++;
            if (sat_flags !== (SAT_EN ? sat_m : '0)) begin
                errors++;
                $display("FAIL rnd_sat[%0d]: got %b want %b", cyc, sat_flags, SAT_EN ? sat_m : '0);
            end
            nsat = sat_clr ? '0 : sat_m;
            case (phase)
                0: if (g >= 0) begin pch = g; pdata = in_data[16*g +: 16]; phase = 1; end
                1: begin
                    model_calc(pch, pdata, sample_rate, y16, s);
                    exp_d = mute[pch] ? 16'h0 : y16;
                    if (s) nsat[pch] = 1'b1;
                    phase = 2;
                end
                default: if (out_ready) begin lg_m = pch; phase = 0; end
            endcase
            sat_m = nsat;
            tick();
        end
        in_valid = '0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_step();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_mute();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
